// File: rtl/led_arbiter.sv
// Time-shares the 7-LED bank between display requesters with round-robin, hold and victory preemption.
// Optional eviction statistics via LED_ARBITER_STATS_EN.
module led_arbiter #(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned HOLD_TICKS    = 8,
    parameter int unsigned TIMEOUT_TICKS = 64,
    parameter int unsigned CW            = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [NREQ-1:0]   req,
    input  logic [7*NREQ-1:0] leds_in,
    output logic [NREQ-1:0]   grant,
    output logic [1:0]        owner,
    output logic              busy,
    output logic [6:0]        leds_out
`ifdef LED_ARBITER_STATS_EN
    ,
    output logic [7:0]        evict_cnt
`endif
);

    localparam int unsigned OW  = 2;
    localparam int unsigned PRI = NREQ - 1;
    localparam int unsigned NRR = NREQ - 1;

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [OW-1:0]   last_rr;
    logic [OW-1:0]   rr_pick;
    logic [OW-1:0]   pick;
    int unsigned     best_d;
    logic [6:0]      own_leds;
    logic            preempt;
    logic            release_c;
    logic            timeout;

    // Round-robin pick: smallest rotational distance after last_rr among set requests.
    always_comb begin
        rr_pick = '0;
        best_d  = NRR;
        for (int unsigned j = 0; j < NRR; j++) begin
            if (req[j] && ((j + NRR - 1 - 32'(last_rr)) % NRR) < best_d) begin
                best_d  = (j + NRR - 1 - 32'(last_rr)) % NRR;
                rr_pick = OW'(j);
            end
        end
        pick = req[PRI] ? OW'(PRI) : rr_pick;
    end

    always_comb begin
        own_leds = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) own_leds = leds_in[7*i +: 7];
        end
    end

    // Exit conditions use the pre-increment counter; grant is one-hot of owner while in OWN.
    always_comb begin
        preempt   = req[PRI] && !grant[PRI];
        release_c = !(|(req & grant)) && (cnt >= CW'(HOLD_TICKS));
        timeout   = !grant[PRI] && (cnt >= CW'(TIMEOUT_TICKS))
                    && (|(req[NRR-1:0] & ~grant[NRR-1:0]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            owner     <= '0;
            busy      <= 1'b0;
            leds_out  <= '0;
            cnt       <= '0;
            last_rr   <= OW'(NRR - 1);
`ifdef LED_ARBITER_STATS_EN
            evict_cnt <= '0;
`endif
        end else begin
            case (state)
                OWN: begin
                    if (preempt || release_c || timeout) begin
                        state    <= GAP;
                        grant    <= '0;
                        busy     <= 1'b0;
                        leds_out <= '0;
`ifdef LED_ARBITER_STATS_EN
                        if ((preempt || timeout) && evict_cnt != 8'hFF)
                            evict_cnt <= evict_cnt + 8'd1;
`endif
                    end else begin
                        leds_out <= own_leds;
                        if (tick && cnt < CW'(TIMEOUT_TICKS))
                            cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    // IDLE and GAP arbitrate identically; GAP never lasts more than one cycle.
                    leds_out <= '0;
                    if (|req) begin
                        state <= OWN;
                        grant <= NREQ'(1) << pick;
                        owner <= pick;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        if (!req[PRI]) last_rr <= rr_pick;
                    end else begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
